// File: rtl/ram_sp_arb.sv
// Single-port RAM arbiter: N_REQ requesters share one RAM port, and read data is returned to the requester that issued it.
// Build option RAM_SP_ARB_RR_EN selects round-robin arbitration; without it, arbitration is fixed priority (lowest index wins).
module ram_sp_arb #(
    parameter int N_REQ   = 2,
    parameter int D_WIDTH = 32,
    parameter int D_DEPTH = 64,
    parameter int REG_OUT = 1,
    localparam int AW     = $clog2(D_DEPTH),
    localparam int IW     = $clog2(N_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [N_REQ-1:0]              req_valid_i,
    output logic [N_REQ-1:0]              req_ready_o,
    input  logic [N_REQ-1:0]              req_wr_i,
    input  logic [N_REQ-1:0][AW-1:0]      req_addr_i,
    input  logic [N_REQ-1:0][D_WIDTH-1:0] req_data_i,
    output logic [N_REQ-1:0]              rsp_valid_o,
    output logic [D_WIDTH-1:0]            rsp_data_o,
    output logic                          ram_wr_en_o,
    output logic                          ram_rd_en_o,
    output logic [AW-1:0]                 ram_addr_o,
    output logic [D_WIDTH-1:0]            ram_wr_data_o,
    input  logic [D_WIDTH-1:0]            ram_rd_data_i
);

    // Handshake: requester n transfers in any cycle where req_valid_i[n] && req_ready_o[n].
    // req_ready_o is a combinational function of req_valid_i. It is one-hot or zero, and it is never 1 for an idle
    // requester. Requesters must not make req_valid_i depend on req_ready_o.
    logic          gnt_hit;
    logic [IW-1:0] gnt_idx;
    logic          gnt_any;
    logic          rd_fire;

`ifdef RAM_SP_ARB_RR_EN
    logic [IW-1:0] last_q;

    // Search the indices above the last grant first, then wrap around to index 0.
    always_comb begin
        gnt_hit = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!gnt_hit && req_valid_i[i] && (i > int'(last_q))) begin
                gnt_hit = 1'b1;
                gnt_idx = IW'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!gnt_hit && req_valid_i[i] && (i <= int'(last_q))) begin
                gnt_hit = 1'b1;
                gnt_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= IW'(N_REQ - 1);
        end else if (gnt_any) begin
            last_q <= gnt_idx;
        end
    end
`else
    always_comb begin
        gnt_hit = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!gnt_hit && req_valid_i[i]) begin
                gnt_hit = 1'b1;
                gnt_idx = IW'(i);
            end
        end
    end
`endif

    assign gnt_any = gnt_hit & ~rst_i;

    always_comb begin
        req_ready_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready_o[i] = gnt_any && (gnt_idx == IW'(i));
        end
    end

    assign ram_addr_o    = req_addr_i[gnt_idx];
    assign ram_wr_data_o = req_data_i[gnt_idx];
    assign ram_wr_en_o   = gnt_any & req_wr_i[gnt_idx];
    assign ram_rd_en_o   = gnt_any & ~req_wr_i[gnt_idx];
    assign rd_fire       = ram_rd_en_o;

    generate
        if (REG_OUT == 0) begin : g_comb_rsp
            always_comb begin
                rsp_valid_o = '0;
                for (int i = 0; i < N_REQ; i++) begin
                    rsp_valid_o[i] = rd_fire && (gnt_idx == IW'(i));
                end
            end
        end else begin : g_reg_rsp
            // The {valid, id} stage lines up with the RAM's one-cycle registered read.
            logic          rd_vld_q;
            logic [IW-1:0] rd_id_q;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    rd_vld_q <= 1'b0;
                    rd_id_q  <= '0;
                end else begin
                    rd_vld_q <= rd_fire;
                    rd_id_q  <= gnt_idx;
                end
            end

            always_comb begin
                rsp_valid_o = '0;
                for (int i = 0; i < N_REQ; i++) begin
                    rsp_valid_o[i] = rd_vld_q && (rd_id_q == IW'(i));
                end
            end
        end
    endgenerate

    assign rsp_data_o = ram_rd_data_i;

endmodule
